// File: rtl/array_sweep_if.sv
`default_nettype none
// ============================================================================
//  Module   : array_sweep_if
//  Purpose  : Host-side bundle for array_sweep_ctrl: sweep request, host
//             write/read port and status flags.
//  Revision : 1.0  initial release
// ============================================================================
interface array_sweep_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             start;
    logic [AW-1:0]    lo;
    logic [AW-1:0]    hi;
    logic [AW-1:0]    off;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, lo, hi, off, wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data, busy, done, err
    );

    modport slave (
        input  start, lo, hi, off, wr_en, wr_addr, wr_data, rd_addr,
        output rd_data, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/array_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : array_sweep_ctrl
//  Purpose  : DEPTH x WIDTH register array with a sweep engine that copies
//             entry (i-off) mod DEPTH into entry i for i = lo..hi ascending.
//             Optional macro ARRAY_SWEEP_ERR_EN enables a sticky error flag
//             for start/write attempts while a sweep is running.
//  Revision : 1.0  initial release
// ============================================================================
module array_sweep_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    array_sweep_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [AW-1:0]    r_idx;
    logic [AW-1:0]    r_hi;
    logic [AW-1:0]    r_off;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Source index wraps naturally because DEPTH is a power of two.
    logic [AW-1:0]    w_src;
    assign w_src = r_idx - r_off;

    assign bus.rd_data = r_mem[bus.rd_addr];
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    // Sweep FSM, array storage and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_hi    <= '0;
            r_off   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    // A same-cycle write lands now, so the first step sees it.
                    if (bus.wr_en) begin
                        r_mem[bus.wr_addr] <= bus.wr_data;
                    end
                    if (bus.start) begin
                        r_idx <= bus.lo;
                        r_hi  <= bus.hi;
                        r_off <= bus.off;
                        if (bus.lo <= bus.hi) begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Host writes and starts are dropped while sweeping.
                    r_mem[r_idx] <= r_mem[w_src];
                    r_idx        <= r_idx + 1'b1;
                    if (r_idx == r_hi) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.wr_en) begin
                        r_mem[bus.wr_addr] <= bus.wr_data;
                    end
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARRAY_SWEEP_ERR_EN
    logic r_err;
    assign bus.err = r_err;

    // Sticky flag: any start or write attempt during a sweep is a protocol error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_RUN && (bus.start || bus.wr_en)) begin
            r_err <= 1'b1;
        end
    end
`else
    assign bus.err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/array_sweep_ctrl.md
ARRAY_SWEEP_CTRL -- requirements
Module: array_sweep_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, number of array entries; power of two, at least 2.
REQ-002 Parameter WIDTH, default 4, bits per array entry.
REQ-003 Localparam AW = clog2(DEPTH), index width.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  request a sweep; sampled in IDLE only.
REQ-007 lo  input  AW  first index of sweep, inclusive.
REQ-008 hi  input  AW  last index of sweep, inclusive.
REQ-009 off  input  AW  source offset; each step copies entry i from entry (i-off) mod DEPTH.
REQ-010 wr_en  input  1  host write strobe.
REQ-011 wr_addr  input  AW  host write index.
REQ-012 wr_data  input  WIDTH  host write data.
REQ-013 rd_addr  input  AW  host read index.
REQ-014 rd_data  output  WIDTH  combinational read of entry rd_addr.
REQ-015 busy  output  1  high while in RUN.
REQ-016 done  output  1  one-cycle pulse marking sweep completion.
REQ-017 err  output  1  sticky protocol-error flag (see Configuration).

Function
REQ-018 Block SHALL own a DEPTH x WIDTH register array and an FSM with states IDLE, RUN, DONE.
REQ-019 IDLE with start=1 at edge T: lo, hi, off latched; idx<=lo; next state RUN if lo<=hi, else DONE (empty range, zero copies).
REQ-020 RUN: each cycle entry idx <= entry (idx-off) mod DEPTH, using the array value at that edge; idx increments by one.
REQ-021 RUN with idx==hi: last copy performed, next state DONE.
REQ-022 DONE: done=1 for exactly one cycle, then IDLE; busy=0 in DONE.
REQ-023 Latency: nonempty sweep of N=hi-lo+1 entries gives busy high cycles T+1..T+N, done high cycle T+N+1; empty range gives done high cycle T+1, busy never high.
REQ-024 Copies proceed ascending, so an entry written earlier in the sweep is the source for a later step (off=1 propagates entry lo-1 upward).
REQ-025 Source index subtraction SHALL wrap modulo DEPTH; off=0 makes each step a no-op rewrite.
REQ-026 Host write accepted only in IDLE and DONE; in RUN it is dropped without side effect.
REQ-027 Host write and start in the same IDLE cycle: write lands at T, first sweep step at T+1 sees it.
REQ-028 start while in RUN or DONE SHALL be ignored; no queuing.
REQ-029 rd_data reflects the array after the most recent edge, including mid-sweep.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, idx=0, all array entries 0, busy=0, done=0, err=0.
REQ-031 Reset during RUN aborts the sweep; no done pulse follows.
REQ-032 After rst deasserts, first start accepted at the first posedge with start=1.

Configuration
REQ-033 Macro ARRAY_SWEEP_ERR_EN defined: err set on start while busy or wr_en while busy; stays set until rst.
REQ-034 Macro ARRAY_SWEEP_ERR_EN undefined: err tied to 0, no error logic generated; all other behaviour identical.

Verification
REQ-035 Load entries {0:0x0,1:0x1,2:0x2,3:0x3}; start lo=1 hi=3 off=1 -> busy 3 cycles, done at T+4, final array {0,0,0,0}.
REQ-036 Same load; start lo=3 hi=1 -> done at T+1, busy never high, array unchanged {0,1,2,3}.
REQ-037 Load {0xA,0xB,0xC,0xD}; start lo=0 hi=0 off=1 -> entry0 becomes 0xD (wrap from index 3), done at T+2.
REQ-038 wr_en addr=2 data=0xF during RUN of lo=0 hi=3 off=0 -> write dropped, entry2 unchanged; with ARRAY_SWEEP_ERR_EN, err=1 next cycle and held.
REQ-039 Assert rst at T+2 of a 4-entry sweep -> array all 0, busy=0, no done pulse; later start lo=0 hi=3 off=2 on fresh loads completes normally.
REQ-040 start at T together with wr_en addr=0 data=0x5, lo=1 hi=1 off=1 -> entry1 becomes 0x5 at T+1, done at T+2.
